aes_ctr_engine: RTL
===================

# aes_ctr_engine

Counter-mode (CTR) stream engine for the AES datapath. It accepts a key and an initial counter block, then takes plaintext or ciphertext blocks over a valid/ready stream. For each block it issues the current counter value to an external AES encryption core, and XORs the returned keystream with the buffered data. The engine generalises the single-shot core flow to multi-block streams with a configurable number of in-flight blocks and full output backpressure.

## Interface
- KEY_LEN, 256, AES key width; drives core_key.
- DATA_LEN, 128, block width.
- NUMS_OF_ROUND, 14, AES round count; sets the default key setup wait.
- KEY_SETUP_CYCLES, NUMS_OF_ROUND+1, cycles core_key_valid is held before the first block is issued.
- CTR_LEN, 32, width of the incrementing low field of the counter block.
- FIFO_DEPTH, 16, data/keystream buffer depth; must be a power of 2, at least 2.
- MAX_OUTSTANDING, 16, maximum blocks issued to the core and not yet returned; at least 1 and at most FIFO_DEPTH. Use 1 for an iterative core.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- cfg_valid  in  1  key/IV offer.
- cfg_ready  out  1  engine idle; accepts cfg.
- cfg_key  in  KEY_LEN  cipher key.
- cfg_iv  in  DATA_LEN  initial counter block.
- s_valid  in  1  input block valid.
- s_ready  out  1  input block accepted.
- s_data  in  DATA_LEN  plaintext or ciphertext block.
- s_last  in  1  final block of the stream.
- m_valid  out  1  output block valid.
- m_ready  in  1  sink ready.
- m_data  out  DATA_LEN  s_data XOR keystream.
- m_last  out  1  final output block.
- core_valid  out  1  one-cycle issue strobe (the core's data_valid_in).
- core_block  out  DATA_LEN  counter block (the core's plain_text).
- core_key_valid  out  1  key valid level (the core's key_valid_in).
- core_key  out  KEY_LEN  latched key (the core's cipher_key).
- core_valid_ret  in  1  core result strobe (the core's data_valid_out).
- core_result  in  DATA_LEN  keystream block (the core's cipher_text).
- busy  out  1  state is not IDLE.
- ctr_wrap  out  1  sticky flag: the counter field wrapped.

## Operation
- States: IDLE, KEYSETUP, RUN, DRAIN.
- **IDLE**
  - cfg_ready=1.
  - On cfg_valid: latch cfg_key into core_key and cfg_iv into ctr, clear ctr_wrap, load the setup counter with KEY_SETUP_CYCLES-1, go to KEYSETUP.
- **KEYSETUP**
  - core_key_valid=1, which stays high through RUN and DRAIN.
  - Decrement the setup counter; go to RUN at 0.
- **RUN**
  - s_ready = (data_cnt < FIFO_DEPTH) && (inflight < MAX_OUTSTANDING), where inflight = data_cnt − ks_cnt.
  - On an s handshake:
    - push {s_data, s_last} into the data FIFO;
    - next cycle, core_valid=1 and core_block = ctr at handshake;
    - ctr low CTR_LEN bits increment modulo 2^CTR_LEN; upper DATA_LEN−CTR_LEN bits are unchanged;
    - on the all-ones→0 transition, set ctr_wrap. The stream continues.
  - On an s handshake with s_last=1, go to DRAIN.
- **DRAIN**
  - s_ready=0.
  - On an m handshake with m_last=1, go to IDLE, drop core_key_valid and zero core_key.
- **Keystream return**
  - When core_valid_ret=1 and inflight>0, push core_result into the keystream FIFO.
  - core_valid_ret with inflight=0, or in IDLE/KEYSETUP, is ignored.
  - The core returns results in issue order.
- **Output**
  - m_valid = ks FIFO not empty.
  - m_data = data_head XOR ks_head and m_last = last_head; both are 0 when m_valid=0.
  - An m handshake pops both FIFOs. A push and a pop in the same cycle on either FIFO is legal; the count is unchanged.
- cfg_valid outside IDLE is ignored.
- Every stream has at least one block. A single block with s_last=1 is legal.

## Timing
- Reset values:
  - state=IDLE;
  - both FIFOs empty;
  - cfg_ready=1, s_ready=0, m_valid=0, m_data=0, m_last=0;
  - core_valid=0, core_block=0, core_key_valid=0, core_key=0;
  - busy=0, ctr_wrap=0.
- Reset mid-stream flushes everything in the same edge. Any core_valid_ret arriving afterwards is ignored.
- cfg handshake at edge t: core_key_valid=1 from t+1. The first s_ready=1 is at t+1+KEY_SETUP_CYCLES.
- s handshake at edge t: core_valid at t+1. If core_valid_ret arrives L cycles after core_valid, m_valid rises at t+1+L+1.
- Throughput is one block per cycle when MAX_OUTSTANDING ≥ core latency + 2 and m_ready=1.
- With m_ready=0, the FIFOs fill and s_ready drops exactly when data_cnt=FIFO_DEPTH. No keystream is lost.

## Test plan
- Core model latency 15, IV=00112233445566778899aabbccddeeff, key=000102…1f, one block of zeros with s_last=1 → m_data=8ea2b7ca516745bfeafc49904b496089, m_last=1. Engine then returns to IDLE with cfg_ready=1.
- 40 back-to-back blocks with m_ready=1 and MAX_OUTSTANDING=16 → outputs in order, each equal to data XOR AES(IV+i); after fill, one output per cycle.
- m_ready held 0 for 100 cycles → s_ready low after exactly 16 accepts. No core_valid_ret is dropped, and all 16 blocks emerge once m_ready=1.
- IV low 32 bits = ffffffff, 2 blocks → core_block low word ffffffff then 00000000, upper 96 bits unchanged. ctr_wrap=1 until the next cfg accept.
- MAX_OUTSTANDING=1 → never two core_valid pulses without an intervening core_valid_ret.
- reset asserted for one cycle with 5 blocks in flight → all outputs at reset values next cycle. Late core_valid_ret pulses produce no m_valid.

Source files
------------

// File: rtl/aes_ctr_engine.sv
// aes_ctr_engine: counter-mode stream engine in front of an external AES encryption core.
// Input blocks wait in a buffer while their counter blocks are in the core; keystream returns in order.
module aes_ctr_engine #(
  parameter int unsigned KEY_LEN          = 256,
  parameter int unsigned DATA_LEN         = 128,
  parameter int unsigned NUMS_OF_ROUND    = 14,
  parameter int unsigned KEY_SETUP_CYCLES = NUMS_OF_ROUND + 1,
  parameter int unsigned CTR_LEN          = 32,
  parameter int unsigned FIFO_DEPTH       = 16,
  parameter int unsigned MAX_OUTSTANDING  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [KEY_LEN-1:0]  cfg_key,
  input  logic [DATA_LEN-1:0] cfg_iv,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_LEN-1:0] s_data,
  input  logic                s_last,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATA_LEN-1:0] m_data,
  output logic                m_last,
  output logic                core_valid,
  output logic [DATA_LEN-1:0] core_block,
  output logic                core_key_valid,
  output logic [KEY_LEN-1:0]  core_key,
  input  logic                core_valid_ret,
  input  logic [DATA_LEN-1:0] core_result,
  output logic                busy,
  output logic                ctr_wrap
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned SetupW = (KEY_SETUP_CYCLES > 1) ? $clog2(KEY_SETUP_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StKeySetup, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [SetupW-1:0]   setup_cnt_q, setup_cnt_d;
  logic [DATA_LEN-1:0] ctr_q, ctr_inc;
  logic [KEY_LEN-1:0]  key_q;
  logic                ctr_wrap_q, core_valid_q;
  logic [DATA_LEN-1:0] core_block_q;

  // Data entries carry their last flag in the top bit.
  logic [DATA_LEN:0]   data_mem [FIFO_DEPTH];
  logic [DATA_LEN-1:0] ks_mem   [FIFO_DEPTH];
  logic [PtrW-1:0]     data_wr_q, ks_wr_q, rd_q;
  logic [CntW-1:0]     data_cnt_q, ks_cnt_q, inflight;
  logic [DATA_LEN:0]   data_head;

  logic cfg_hs, s_hs, m_hs, ks_push, stream_done;

  assign inflight    = data_cnt_q - ks_cnt_q;
  assign cfg_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign cfg_hs      = cfg_ready && cfg_valid;
  assign s_ready     = (state_q == StRun) && (data_cnt_q < CntW'(FIFO_DEPTH)) &&
                       (inflight < CntW'(MAX_OUTSTANDING));
  assign s_hs        = s_valid && s_ready;
  assign m_valid     = (ks_cnt_q != '0);
  assign m_hs        = m_valid && m_ready;
  assign ks_push     = core_valid_ret && (inflight != '0) &&
                       ((state_q == StRun) || (state_q == StDrain));
  assign data_head   = data_mem[rd_q];
  assign m_data      = m_valid ? (data_head[DATA_LEN-1:0] ^ ks_mem[rd_q]) : '0;
  assign m_last      = m_valid && data_head[DATA_LEN];
  assign stream_done = (state_q == StDrain) && m_hs && m_last;

  assign core_valid     = core_valid_q;
  assign core_block     = core_block_q;
  assign core_key_valid = busy;
  assign core_key       = key_q;
  assign ctr_wrap       = ctr_wrap_q;

  // Only the low counter field increments; the upper part of the IV is fixed for the stream.
  always_comb begin
    ctr_inc                = ctr_q;
    ctr_inc[CTR_LEN-1:0]   = ctr_q[CTR_LEN-1:0] + CTR_LEN'(1);
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          state_d     = StKeySetup;
          setup_cnt_d = SetupW'(KEY_SETUP_CYCLES - 1);
        end
      end
      StKeySetup: begin
        if (setup_cnt_q == '0) state_d = StRun;
        else                   setup_cnt_d = setup_cnt_q - SetupW'(1);
      end
      StRun:   if (s_hs && s_last) state_d = StDrain;
      StDrain: if (stream_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      setup_cnt_q  <= '0;
      ctr_q        <= '0;
      key_q        <= '0;
      ctr_wrap_q   <= 1'b0;
      core_valid_q <= 1'b0;
      core_block_q <= '0;
      data_wr_q    <= '0;
      ks_wr_q      <= '0;
      rd_q         <= '0;
      data_cnt_q   <= '0;
      ks_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      setup_cnt_q  <= setup_cnt_d;
      core_valid_q <= s_hs;
      if (cfg_hs) begin
        key_q      <= cfg_key;
        ctr_q      <= cfg_iv;
        ctr_wrap_q <= 1'b0;
      end else if (s_hs) begin
        core_block_q <= ctr_q;
        ctr_q        <= ctr_inc;
        if (&ctr_q[CTR_LEN-1:0]) ctr_wrap_q <= 1'b1;
      end
      if (stream_done) key_q <= '0;
      if (s_hs)    data_wr_q <= data_wr_q + PtrW'(1);
      if (ks_push) ks_wr_q   <= ks_wr_q + PtrW'(1);
      if (m_hs)    rd_q      <= rd_q + PtrW'(1);
      data_cnt_q <= data_cnt_q + CntW'(s_hs) - CntW'(m_hs);
      ks_cnt_q   <= ks_cnt_q + CntW'(ks_push) - CntW'(m_hs);
    end
  end

  always_ff @(posedge clk) begin
    if (s_hs)    data_mem[data_wr_q] <= {s_last, s_data};
    if (ks_push) ks_mem[ks_wr_q]     <= core_result;
  end

endmodule
